// File: rtl/text_overlay_if.sv
// Video, control, char-write and font-ROM signals of text_overlay.
// master = video source/controller/ROM, slave = overlay engine.
interface text_overlay_if #(
  parameter int GLYPH_W   = 16,
  parameter int GLYPH_H   = 32,
  parameter int COLS      = 16,
  parameter int CHAR_BITS = 7,
  parameter int DW        = 24
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int AW = CHAR_BITS + RW;

  logic                 vid_de;
  logic                 vid_hs;
  logic                 vid_vs;
  logic [DW-1:0]        vid_data;
  logic                 out_de;
  logic                 out_hs;
  logic                 out_vs;
  logic [DW-1:0]        out_data;
  logic [11:0]          x_pos;
  logic [11:0]          y_pos;
  logic [1:0]           mode;
  logic                 scale;
  logic [DW-1:0]        fg_color;
  logic [DW-1:0]        bg_color;
  logic                 wr_en;
  logic [CW-1:0]        wr_addr;
  logic [CHAR_BITS-1:0] wr_char;
  logic [AW-1:0]        rom_addr;
  logic [GLYPH_W-1:0]   rom_q;

  modport master (
    output vid_de, vid_hs, vid_vs, vid_data,
    output x_pos, y_pos, mode, scale,
    output fg_color, bg_color,
    output wr_en, wr_addr, wr_char, rom_q,
    input  out_de, out_hs, out_vs, out_data,
    input  rom_addr
  );

  modport slave (
    input  vid_de, vid_hs, vid_vs, vid_data,
    input  x_pos, y_pos, mode, scale,
    input  fg_color, bg_color,
    input  wr_en, wr_addr, wr_char, rom_q,
    output out_de, out_hs, out_vs, out_data,
    output rom_addr
  );
endinterface

// File: rtl/text_overlay.sv
// Text overlay: one line of COLS glyphs blended into video.
// Ports: vpg_pclk, rst (sync, active-high), bus (slave modport).
module text_overlay #(
  parameter int GLYPH_W   = 16,
  parameter int GLYPH_H   = 32,
  parameter int COLS      = 16,
  parameter int CHAR_BITS = 7,
  parameter int ROM_LAT   = 1,
  parameter int DW        = 24
) (
  input  logic         vpg_pclk,
  input  logic         rst,
  text_overlay_if.slave bus
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int BW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int AW = CHAR_BITS + RW;
  localparam int D  = ROM_LAT + 1;
  localparam logic [16:0] WIN_W = 17'(COLS * GLYPH_W);
  localparam logic [16:0] WIN_H = 17'(GLYPH_H);

  typedef struct packed {
    logic          de;
    logic          hs;
    logic          vs;
    logic          win;
    logic [BW-1:0] bidx;
    logic [DW-1:0] data;
  } pipe_t;

  logic [11:0]          x_q, x_d, y_q, y_d;
  logic                 de_q, vs_q;
  logic [11:0]          xp_q, xp_d, yp_q, yp_d;
  logic [1:0]           mode_q, mode_d;
  logic                 scale_q, scale_d;
  logic [CHAR_BITS-1:0] cbuf_q [COLS];
  logic [CHAR_BITS-1:0] cbuf_d [COLS];
  logic [AW-1:0]        rom_addr_q, rom_addr_d;
  pipe_t                pipe_q [D];
  pipe_t                pipe_d [D];
  logic                 out_de_q, out_hs_q, out_vs_q;
  logic                 out_de_d, out_hs_d, out_vs_d;
  logic [DW-1:0]        out_data_q, out_data_d;

  logic [16:0]          x_e, y_e;
  logic [11:0]          dx, dy, dxs, dys;
  logic                 in_win;
  logic [CW-1:0]        col;
  logic [BW-1:0]        bidx;
  logic [RW-1:0]        row;
  logic [CHAR_BITS-1:0] chr;
  pipe_t                pt;
  logic [GLYPH_W-1:0]   glyph_sh;
  logic                 sel;

  // raster position and frame-start control shadowing
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (bus.vid_de) begin
      if (x_q != 12'hFFF) x_d = x_q + 12'd1;
    end else if (de_q) begin
      x_d = '0;
    end
    if (bus.vid_vs) y_d = '0;
    else if (de_q && !bus.vid_de && y_q != 12'hFFF)
      y_d = y_q + 12'd1;
    xp_d    = xp_q;
    yp_d    = yp_q;
    mode_d  = mode_q;
    scale_d = scale_q;
    if (bus.vid_vs && !vs_q) begin
      xp_d    = bus.x_pos;
      yp_d    = bus.y_pos;
      mode_d  = bus.mode;
      scale_d = bus.scale;
    end
  end

  // stage 0: window test and glyph coordinates
  always_comb begin
    x_e = {5'd0, xp_q} + (scale_q ? (WIN_W << 1) : WIN_W);
    y_e = {5'd0, yp_q} + (scale_q ? (WIN_H << 1) : WIN_H);
    in_win = bus.vid_de
           && x_q >= xp_q && {5'd0, x_q} < x_e
           && y_q >= yp_q && {5'd0, y_q} < y_e;
    dx   = x_q - xp_q;
    dy   = y_q - yp_q;
    dxs  = scale_q ? (dx >> 1) : dx;
    dys  = scale_q ? (dy >> 1) : dy;
    col  = CW'(dxs / 12'(GLYPH_W));
    bidx = BW'(dxs % 12'(GLYPH_W));
    row  = RW'(dys);
    chr  = (int'(col) < COLS) ? cbuf_q[col] : '0;
  end

  // old code is returned on a same-cycle write/read of one column
  always_comb begin
    cbuf_d = cbuf_q;
    if (bus.wr_en && int'(bus.wr_addr) < COLS)
      cbuf_d[bus.wr_addr] = bus.wr_char;
  end

  // stage 1 and the delay line matching the ROM latency
  always_comb begin
    rom_addr_d = in_win ? {chr, row} : rom_addr_q;
    pipe_d[0] = '{de: bus.vid_de, hs: bus.vid_hs,
                  vs: bus.vid_vs, win: in_win,
                  bidx: bidx, data: bus.vid_data};
    for (int i = 1; i < D; i++) pipe_d[i] = pipe_q[i-1];
  end

  // output stage: blend
  always_comb begin
    pt       = pipe_q[D-1];
    glyph_sh = bus.rom_q << pt.bidx;
    sel      = glyph_sh[GLYPH_W-1];
    out_de_d = pt.de;
    out_hs_d = pt.hs;
    out_vs_d = pt.vs;
    out_data_d = pt.data;
    if (pt.win) begin
      unique case (mode_q)
        2'd0: out_data_d = pt.data;
        2'd1: out_data_d = sel ? bus.fg_color : bus.bg_color;
        2'd2: out_data_d = sel ? bus.fg_color : pt.data;
        2'd3: out_data_d = sel ? ~pt.data : pt.data;
      endcase
    end
  end

  always_ff @(posedge vpg_pclk) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      de_q       <= 1'b0;
      vs_q       <= 1'b0;
      xp_q       <= '0;
      yp_q       <= '0;
      mode_q     <= '0;
      scale_q    <= 1'b0;
      rom_addr_q <= '0;
      for (int i = 0; i < D; i++) pipe_q[i] <= '0;
      out_de_q   <= 1'b0;
      out_hs_q   <= 1'b0;
      out_vs_q   <= 1'b0;
      out_data_q <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      de_q       <= bus.vid_de;
      vs_q       <= bus.vid_vs;
      xp_q       <= xp_d;
      yp_q       <= yp_d;
      mode_q     <= mode_d;
      scale_q    <= scale_d;
      rom_addr_q <= rom_addr_d;
      pipe_q     <= pipe_d;
      out_de_q   <= out_de_d;
      out_hs_q   <= out_hs_d;
      out_vs_q   <= out_vs_d;
      out_data_q <= out_data_d;
    end
  end

  // character buffer survives reset
  always_ff @(posedge vpg_pclk) begin
    cbuf_q <= cbuf_d;
  end

  assign bus.out_de   = out_de_q;
  assign bus.out_hs   = out_hs_q;
  assign bus.out_vs   = out_vs_q;
  assign bus.out_data = out_data_q;
  assign bus.rom_addr = rom_addr_q;
endmodule

// File: tb/tb_text_overlay.sv
// Self-checking bench for text_overlay on a reduced raster.
// Geometric reference model plus a blend vector table.
module tb_text_overlay;
  localparam int GW = 16;
  localparam int GH = 8;
  localparam int NC = 4;
  localparam int HA = 160;
  localparam int HB = 10;
  localparam int VA = 24;
  localparam int VB = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  text_overlay_if #(.GLYPH_W(GW), .GLYPH_H(GH), .COLS(NC),
                    .CHAR_BITS(7), .DW(24)) bus();

  text_overlay #(.GLYPH_W(GW), .GLYPH_H(GH), .COLS(NC),
                 .CHAR_BITS(7), .ROM_LAT(1), .DW(24))
    dut (.vpg_pclk(clk), .rst(rst), .bus(bus));

  function automatic logic [15:0] rom_fn(input logic [6:0] c,
                                         input logic [2:0] r);
    if (c == 7'h7F) return 16'hFFFF;
    if (c == 7'h00) return 16'h0000;
    return 16'(int'(c) * 1021 + int'(r) * 97 + 23100);
  endfunction

  always @(posedge clk)
    bus.rom_q <= rom_fn(bus.rom_addr[9:3], bus.rom_addr[2:0]);

  typedef struct {
    bit          v;
    logic        de, hs, vs;
    logic [23:0] d;
  } exp_t;

  exp_t        ring [8];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [6:0]  cb_m [NC];
  int          sh_xp, sh_yp, sh_md, sh_sc;
  logic        vs_prev;
  bit          pos_ok;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // one pixel clock: drive, predict, advance, check
  task automatic px(input logic de, input logic hs, input logic vs,
                    input logic [23:0] d, input int x, input int y,
                    input logic r);
    logic [23:0] e;
    logic [9:0]  ra_e;
    bit          ra_chk;
    int          s, dx, dy;
    logic [6:0]  c;
    logic [15:0] g;
    logic        sel;
    exp_t        z;
    bus.vid_de = de;
    bus.vid_hs = hs;
    bus.vid_vs = vs;
    bus.vid_data = d;
    rst = r;
    e = d;
    ra_chk = 0;
    ra_e = '0;
    if (de && pos_ok && !r) begin
      s = sh_sc + 1;
      if (x >= sh_xp && x < sh_xp + NC * GW * s &&
          y >= sh_yp && y < sh_yp + GH * s) begin
        dx = (x - sh_xp) / s;
        dy = (y - sh_yp) / s;
        c = cb_m[2'(dx / GW)];
        g = rom_fn(c, 3'(dy));
        g = g << (dx % GW);
        sel = g[GW-1];
        ra_chk = 1;
        ra_e = {c, 3'(dy)};
        case (sh_md)
          1: e = sel ? bus.fg_color : bus.bg_color;
          2: e = sel ? bus.fg_color : d;
          3: e = sel ? ~d : d;
          default: e = d;
        endcase
      end
    end
    z = '{v: 1'b1, de: 1'b0, hs: 1'b0, vs: 1'b0, d: 24'd0};
    if (r) begin
      ring[(cyc + 1) % 8] = z;
      ring[(cyc + 2) % 8] = z;
      ring[(cyc + 3) % 8] = z;
      sh_xp = 0; sh_yp = 0; sh_md = 0; sh_sc = 0;
      vs_prev = 0;
      pos_ok = 0;
    end else begin
      ring[(cyc + 3) % 8] = '{v: 1'b1, de: de, hs: hs, vs: vs, d: e};
      if (vs && !vs_prev) begin
        sh_xp = int'(bus.x_pos);
        sh_yp = int'(bus.y_pos);
        sh_md = int'(bus.mode);
        sh_sc = int'(bus.scale);
        pos_ok = 1;
      end
      vs_prev = vs;
    end
    if (bus.wr_en) cb_m[bus.wr_addr] = bus.wr_char;
    @(posedge clk);
    #1;
    cyc++;
    if (ra_chk) chk("rom_addr", 32'(bus.rom_addr), 32'(ra_e));
    if (ring[cyc % 8].v) begin
      chk("sync", {bus.out_de, bus.out_hs, bus.out_vs},
          {ring[cyc % 8].de, ring[cyc % 8].hs, ring[cyc % 8].vs});
      chk("data", 32'(bus.out_data), 32'(ring[cyc % 8].d));
      ring[cyc % 8].v = 0;
    end
  endtask

  task automatic frame(input int xp, input int yp, input int md,
                       input int sc, input bit wr,
                       input int chg_line, input int chg_xp,
                       input int rst_line, input int rst_px);
    bit act, de, hs, vs, r;
    bus.x_pos = 12'(xp);
    bus.y_pos = 12'(yp);
    bus.mode  = 2'(md);
    bus.scale = 1'(sc);
    for (int ln = 0; ln < VB + VA; ln++) begin
      act = ln >= VB;
      if (chg_line >= 0 && ln == VB + chg_line) bus.x_pos = 12'(chg_xp);
      for (int p = 0; p < HA + HB; p++) begin
        de = act && p < HA;
        hs = p >= HA + 2 && p < HA + 6;
        vs = ln == 0;
        r  = rst_line >= 0 && ln == VB + rst_line && p == rst_px;
        bus.wr_en   = wr && ($urandom_range(0, 7) == 0);
        bus.wr_addr = 2'($urandom_range(0, NC - 1));
        bus.wr_char = 7'($urandom_range(0, 127));
        px(de, hs, vs, 24'($urandom), de ? p : -1, ln - VB, r);
      end
    end
    bus.wr_en = 0;
  endtask

  typedef struct {
    logic [1:0]  md;
    logic [6:0]  ch;
    logic [23:0] vid, fg, bg, exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{2'd3, 7'h7F, 24'h123456, 24'h000000, 24'h000000, 24'hEDCBA9};
    tbl[1] = '{2'd2, 7'h00, 24'h123456, 24'hFFFFFF, 24'h000000, 24'h123456};
    tbl[2] = '{2'd2, 7'h7F, 24'h123456, 24'hABCDEF, 24'h000000, 24'hABCDEF};
    tbl[3] = '{2'd1, 7'h7F, 24'h123456, 24'h00FF00, 24'hFF0000, 24'h00FF00};
    tbl[4] = '{2'd1, 7'h00, 24'h123456, 24'h00FF00, 24'hFF0000, 24'hFF0000};
    tbl[5] = '{2'd0, 7'h7F, 24'h654321, 24'hFFFFFF, 24'h000000, 24'h654321};
    tbl[6] = '{2'd3, 7'h00, 24'h0F0F0F, 24'h000000, 24'h000000, 24'h0F0F0F};
    tbl[7] = '{2'd3, 7'h7F, 24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000};

    for (int i = 0; i < 8; i++) ring[i].v = 0;
    sh_xp = 0; sh_yp = 0; sh_md = 0; sh_sc = 0;
    vs_prev = 0;
    pos_ok = 0;
    rst = 1;
    bus.vid_de = 0; bus.vid_hs = 0; bus.vid_vs = 0; bus.vid_data = '0;
    bus.x_pos = 0; bus.y_pos = 0; bus.mode = 0; bus.scale = 0;
    bus.fg_color = 24'hFFFFFF; bus.bg_color = 24'h000000;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_char = 0;

    for (int i = 0; i < 4; i++) px(0, 0, 0, 24'($urandom), -1, -1, 1);
    chk("reset_de", {31'd0, bus.out_de}, 32'd0);
    chk("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
    for (int i = 0; i < NC; i++) begin
      bus.wr_en = 1;
      bus.wr_addr = 2'(i);
      bus.wr_char = (i == 0) ? 7'h41 : 7'($urandom_range(1, 126));
      px(0, 0, 0, 24'($urandom), -1, -1, 0);
    end
    bus.wr_en = 0;

    // bypass frame, overlay glyph 'A' at 1x and 2x
    frame(30, 4, 0, 0, 0, -1, 0, -1, 0);
    frame(30, 4, 1, 0, 0, -1, 0, -1, 0);
    frame(30, 4, 1, 1, 0, -1, 0, -1, 0);

    for (int i = 0; i < 8; i++) begin
      bus.x_pos = 0; bus.y_pos = 0; bus.scale = 0;
      bus.mode = tbl[i].md;
      bus.fg_color = tbl[i].fg;
      bus.bg_color = tbl[i].bg;
      bus.wr_en = 1; bus.wr_addr = 0; bus.wr_char = tbl[i].ch;
      px(0, 0, 0, 24'($urandom), -1, -1, 0);
      bus.wr_en = 0;
      px(0, 0, 1, 24'($urandom), -1, -1, 0);
      px(0, 0, 1, 24'($urandom), -1, -1, 0);
      px(0, 0, 0, 24'($urandom), -1, -1, 0);
      px(0, 0, 0, 24'($urandom), -1, -1, 0);
      px(1, 0, 0, tbl[i].vid, 0, 0, 0);
      px(1, 0, 0, tbl[i].vid, 1, 0, 0);
      px(1, 0, 0, tbl[i].vid, 2, 0, 0);
      chk("blend_vec", 32'(bus.out_data), 32'(tbl[i].exp));
      px(1, 0, 0, tbl[i].vid, 3, 0, 0);
      for (int k = 0; k < 4; k++) px(0, 0, 0, 24'($urandom), -1, -1, 0);
    end

    // mid-frame x_pos change, then the frame that picks it up
    bus.fg_color = 24'h00FFFF; bus.bg_color = 24'h200020;
    frame(30, 2, 1, 0, 0, 3, 100, -1, 0);
    frame(100, 2, 1, 0, 0, -1, 0, -1, 0);

    // reset inside an active line, then overlay resumes
    frame(10, 2, 3, 0, 0, -1, 0, 5, 40);
    frame(10, 2, 3, 0, 0, -1, 0, -1, 0);

    for (int f = 0; f < 4; f++) begin
      bus.fg_color = 24'($urandom);
      bus.bg_color = 24'($urandom);
      frame($urandom_range(0, 150), $urandom_range(0, 20),
            $urandom_range(0, 3), $urandom_range(0, 1), 1,
            -1, 0, -1, 0);
    end
    for (int k = 0; k < 6; k++) px(0, 0, 0, 24'($urandom), -1, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
